// File: rtl/fab_clk_div.sv
// fab_clk_div: multi-channel programmable clock-enable and divided-clock generator.
// Ratio writes wait in a pending slot and commit only at a period wrap, or at once while a channel is idle.
module fab_clk_div #(
    parameter int NUM_CH       = 3,
    parameter int DIV_W        = 5,
    parameter int SEL_W        = 2,
    parameter int DIV_INIT     = 3,
    parameter int LOCK_PERIODS = 2
) (
    input  logic              FAB_CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              CFG_WR,
    input  logic [SEL_W-1:0]  CFG_SEL,
    input  logic [DIV_W-1:0]  CFG_DIV,
    input  logic              CFG_BYPASS,
    output logic [NUM_CH-1:0] CE,
    output logic [NUM_CH-1:0] CLKOUT,
    output logic [NUM_CH-1:0] LOCK,
    output logic [NUM_CH-1:0] PENDING
);
    localparam int LW = $clog2(LOCK_PERIODS + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_PERIODS - 1);
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [DIV_W-1:0] div_q, div_d, pdiv_q, pdiv_d, cnt_q, cnt_d, half;
            logic             byp_q, byp_d, pbyp_q, pbyp_d, pend_q, pend_d;
            logic             ce_q, ce_d, clk_q, clk_d, lock_q, lock_d;
            logic [LW-1:0]    lcnt_q, lcnt_d;
            logic             en, wr_hit, wrap, commit;
            always_comb begin
                en     = CH_EN[c];
                wr_hit = CFG_WR && (CFG_SEL == SEL_W'(c));
                // Comparing against N-1 keeps DIV = all-ones inside DIV_W bits
                wrap   = en && (cnt_q == (byp_q ? '0 : div_q));
                commit = pend_q && (wrap || !en);
                div_d  = commit ? pdiv_q : div_q;
                byp_d  = commit ? pbyp_q : byp_q;
                pdiv_d = wr_hit ? CFG_DIV : pdiv_q;
                pbyp_d = wr_hit ? CFG_BYPASS : pbyp_q;
                pend_d = wr_hit || (pend_q && !commit);
                // N>>1 of the ratio that governs the period starting after this edge
                half   = byp_d ? '0 : DIV_W'(({1'b0, div_d} + (DIV_W + 1)'(1)) >> 1);
                cnt_d  = (!en || wrap) ? '0 : cnt_q + DIV_W'(1);
                ce_d   = wrap;
                clk_d  = en && (cnt_d < half);
                lcnt_d = (commit || !en) ? '0 : (wrap && !lock_q) ? lcnt_q + LW'(1) : lcnt_q;
                lock_d = en && !commit && (lock_q || (wrap && lcnt_q == LOCK_LAST));
            end
            always_ff @(posedge FAB_CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    div_q  <= DIV_W'(DIV_INIT);
                    byp_q  <= 1'b0;
                    pdiv_q <= '0;
                    pbyp_q <= 1'b0;
                    pend_q <= 1'b0;
                    cnt_q  <= '0;
                    ce_q   <= 1'b0;
                    clk_q  <= 1'b0;
                    lock_q <= 1'b0;
                    lcnt_q <= '0;
                end else begin
                    div_q  <= div_d;
                    byp_q  <= byp_d;
                    pdiv_q <= pdiv_d;
                    pbyp_q <= pbyp_d;
                    pend_q <= pend_d;
                    cnt_q  <= cnt_d;
                    ce_q   <= ce_d;
                    clk_q  <= clk_d;
                    lock_q <= lock_d;
                    lcnt_q <= lcnt_d;
                end
            end
            assign CE[c]      = ce_q;
            assign CLKOUT[c]  = clk_q;
            assign LOCK[c]    = lock_q;
            assign PENDING[c] = pend_q;
        end
    endgenerate
endmodule
